crc_engine: RTL

CRC_ENGINE -- requirements
Module: crc_engine

---
 rtl/crc_engine.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/crc_engine.sv
// CRC-32 register-mapped engine: MSB-first, non-reflected, no final XOR.
// Ports: CLK, nRST (async low), write_enable, register_select,
//   write_data, read_data (comb readback), crc_done (1-cycle pulse).
// Option: define CRC_ENGINE_FAST_EN for 8 bits per BUSY cycle.

package crc_pkg;
  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    CRC_CONTROL = 3'd1,
    CRC_STATUS  = 3'd2,
    CRC_INPUT   = 3'd3,
    CRC_OUTPUT  = 3'd4,
    SEL_OTHER   = 3'd5
  } regsel_t;
endpackage

module crc_engine
  import crc_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] POLY = 32'h04C11DB7
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 write_enable,
  input  regsel_t              register_select,
  input  logic [WORD_SIZE-1:0] write_data,
  output logic [WORD_SIZE-1:0] read_data,
  output logic                 crc_done
);

`ifdef CRC_ENGINE_FAST_EN
  localparam int STEPS = 8;
`else
  localparam int STEPS = 1;
`endif
  localparam int CYCLES = WORD_SIZE / STEPS;
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;

  logic [CW-1:0]        cnt;
  logic                 enable;
  logic                 init_zero;
  logic                 overrun;
  logic [WORD_SIZE-1:0] result;
  logic [WORD_SIZE-1:0] work;
  logic [WORD_SIZE-1:0] shift;
  logic [WORD_SIZE-1:0] in_latch;
  logic [WORD_SIZE-1:0] step;

  logic ctrl_wr;
  logic stat_wr;
  logic in_wr;
  logic clear;
  logic accept;
  logic busy;
  logic last;
  logic abort;

  // Advance the CRC by STEPS message bits, MSB first.
  function automatic logic [WORD_SIZE-1:0] crc_step(
    input logic [WORD_SIZE-1:0] c_in,
    input logic [STEPS-1:0]     bits
  );
    logic [WORD_SIZE-1:0] c;
    logic                 fb;
    c = c_in;
    for (int i = STEPS - 1; i >= 0; i--) begin
      fb = c[WORD_SIZE-1] ^ bits[i];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  assign ctrl_wr = write_enable && (register_select == CRC_CONTROL);
  assign stat_wr = write_enable && (register_select == CRC_STATUS);
  assign in_wr   = write_enable && (register_select == CRC_INPUT);
  assign clear   = ctrl_wr && write_data[1];
  assign busy    = (state == BUSY);
  assign accept  = in_wr && enable && !busy;
  assign last    = (cnt == CW'(CYCLES - 1));
  assign abort   = busy && clear;
  assign step    = crc_step(work, shift[WORD_SIZE-1 -: STEPS]);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (abort || last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt       <= '0;
      enable    <= 1'b0;
      init_zero <= 1'b0;
      overrun   <= 1'b0;
      result    <= '1;
      work      <= '1;
      shift     <= '0;
      in_latch  <= '0;
      crc_done  <= 1'b0;
    end else begin
      crc_done <= 1'b0;

      if (ctrl_wr) begin
        enable    <= write_data[0];
        init_zero <= write_data[2];
      end

      // INIT_ZERO is taken from the same write that carries CLEAR.
      if (clear) begin
        result <= write_data[2] ? '0 : '1;
      end

      if (stat_wr && write_data[1]) begin
        overrun <= 1'b0;
      end

      // Disabled writes are dropped before the overrun check.
      if (in_wr && enable && busy) begin
        overrun <= 1'b1;
      end

      if (accept) begin
        shift    <= write_data;
        in_latch <= write_data;
        work     <= result;
        cnt      <= '0;
      end else if (abort) begin
        cnt <= '0;
      end else if (busy) begin
        work  <= step;
        shift <= shift << STEPS;
        if (last) begin
          cnt      <= '0;
          result   <= step;
          crc_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    read_data = '0;
    unique case (register_select)
      CRC_CONTROL: begin
        read_data[0] = enable;
        read_data[2] = init_zero;
      end
      CRC_STATUS: begin
        read_data[0] = busy;
        read_data[1] = overrun;
      end
      CRC_INPUT:  read_data = in_latch;
      CRC_OUTPUT: read_data = result;
      default:    read_data = '0;
    endcase
  end

endmodule
